// File: rtl/data_memory_ctrl_if.sv
// Request/response bundle between the execute stage (master) and the data memory (slave).
// The slave also reports when its reset clear sweep is still running.
interface data_memory_ctrl_if #(
   parameter int BITS      = 32,
   parameter int ADDR_BITS = 20
);
   logic                 req_valid;
   logic                 req_ready;
   logic                 req_write;
   logic [1:0]           req_size;
   logic                 req_signed;
   logic [ADDR_BITS-1:0] address;
   logic [BITS-1:0]      wdata;
   logic                 rsp_valid;
   logic [BITS-1:0]      rdata;
   logic                 err_misaligned;
   logic                 err_range;
   logic                 busy;

   modport master (
      output req_valid, req_write, req_size, req_signed, address, wdata,
      input  req_ready, rsp_valid, rdata, err_misaligned, err_range, busy
   );

   modport slave (
      input  req_valid, req_write, req_size, req_signed, address, wdata,
      output req_ready, rsp_valid, rdata, err_misaligned, err_range, busy
   );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory with byte/half/word/double access and sign/zero-extending loads.
// After reset the array is cleared one word per cycle before requests are accepted.
module data_memory_ctrl #(
   parameter int BITS      = 32,
   parameter int ADDR_BITS = 20,
   parameter int DEPTH     = 100
) (
   input logic                 clock,
   input logic                 reset,
   data_memory_ctrl_if.slave   bus
);
   localparam int NB    = BITS / 8;
   localparam int LB    = $clog2(NB);
   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic {S_CLEAR, S_READY} state_t;

   state_t               r_state;
   logic [PTR_W-1:0]     r_clear_ptr;
   logic                 r_busy;
   logic                 r_ready;
   logic [BITS-1:0]      r_mem [DEPTH];
   logic                 r_rsp_valid;
   logic [BITS-1:0]      r_rdata;
   logic                 r_err_mis;
   logic                 r_err_rng;

   logic                 w_ready;
   logic                 w_accept;
   logic [ADDR_BITS-1:0] w_word_idx;
   logic [PTR_W-1:0]     w_idx;
   logic [LB-1:0]        w_off;
   logic                 w_rng;
   logic                 w_mis;
   logic                 w_err;
   logic [NB-1:0]        w_be;
   logic [BITS-1:0]      w_wdata_sh;
   logic [BITS-1:0]      w_rword;
   logic [BITS-1:0]      w_rshift;
   logic [BITS-1:0]      w_load;

   function automatic logic [NB-1:0] lane_mask(input logic [1:0] sz, input logic [LB-1:0] off);
      logic [NB-1:0] m;
      case (sz)
         2'd0:    m = NB'(1);
         2'd1:    m = NB'(3);
         2'd2:    m = NB'(15);
         default: m = '1;
      endcase
      return m << off;
   endfunction

   function automatic logic [BITS-1:0] extend_load(input logic [BITS-1:0] v, input logic [1:0] sz,
                                                   input logic sgn);
      logic [BITS-1:0] keep;
      logic            msb;
      case (sz)
         2'd0:    begin keep = BITS'(8'hFF);         msb = v[7];      end
         2'd1:    begin keep = BITS'(16'hFFFF);      msb = v[15];     end
         2'd2:    begin keep = BITS'(32'hFFFF_FFFF); msb = v[31];     end
         default: begin keep = '1;                   msb = v[BITS-1]; end
      endcase
      return (v & keep) | ({BITS{sgn & msb}} & ~keep);
   endfunction

   // Ready and busy drop/rise with reset itself, not one cycle later.
   assign w_ready  = r_ready & ~reset;
   assign w_accept = bus.req_valid & w_ready;

   assign w_word_idx = bus.address >> LB;
   assign w_idx      = w_word_idx[PTR_W-1:0];
   assign w_off      = bus.address[LB-1:0];
   assign w_rng      = (w_word_idx >= ADDR_BITS'(DEPTH));

   always_comb begin
      w_mis = 1'b0;
      case (bus.req_size)
         2'd0:    w_mis = 1'b0;
         2'd1:    w_mis = w_off[0];
         2'd2:    w_mis = (w_off[1:0] != 2'b00);
         default: w_mis = (BITS == 32) ? 1'b1 : (w_off != '0);
      endcase
   end

   assign w_err      = w_mis | w_rng;
   assign w_be       = lane_mask(bus.req_size, w_off);
   assign w_wdata_sh = bus.wdata << {w_off, 3'b000};
   assign w_rword    = w_rng ? '0 : r_mem[w_idx];
   assign w_rshift   = w_rword >> {w_off, 3'b000};
   assign w_load     = extend_load(w_rshift, bus.req_size, bus.req_signed);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_CLEAR;
         r_clear_ptr <= '0;
         r_busy      <= 1'b1;
         r_ready     <= 1'b0;
      end else begin
         case (r_state)
            S_CLEAR: begin
               if (r_clear_ptr == PTR_W'(DEPTH - 1)) begin
                  r_state <= S_READY;
                  r_busy  <= 1'b0;
                  r_ready <= 1'b1;
               end else begin
                  r_clear_ptr <= r_clear_ptr + 1'b1;
               end
            end
            default: r_state <= S_READY;
         endcase
      end
   end

   // Array has no reset of its own; the sweep is what clears it.
   always_ff @(posedge clock) begin
      if (r_state == S_CLEAR && !reset) begin
         r_mem[r_clear_ptr] <= '0;
      end else if (w_accept && bus.req_write && !w_err) begin
         for (int b = 0; b < NB; b++)
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_rsp_valid <= 1'b0;
         r_rdata     <= '0;
         r_err_mis   <= 1'b0;
         r_err_rng   <= 1'b0;
      end else if (w_accept) begin
         r_rsp_valid <= 1'b1;
         r_rdata     <= (w_err || bus.req_write) ? '0 : w_load;
         r_err_mis   <= w_mis;
         r_err_rng   <= w_rng;
      end else begin
         r_rsp_valid <= 1'b0;
      end
   end

   assign bus.req_ready      = w_ready;
   assign bus.busy           = r_busy | reset;
   assign bus.rsp_valid      = r_rsp_valid & ~reset;
   assign bus.rdata          = reset ? '0 : r_rdata;
   assign bus.err_misaligned = r_err_mis & ~reset;
   assign bus.err_range      = r_err_rng & ~reset;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: 32-bit and 64-bit instances, clear sweep,
// sub-word stores/loads, alignment/range errors and reset during traffic.
module tb_data_memory_ctrl;
   logic clock = 1'b0;
   logic reset32, reset64;
   always #5 clock = ~clock;

   data_memory_ctrl_if #(.BITS(32), .ADDR_BITS(20)) bus32 ();
   data_memory_ctrl_if #(.BITS(64), .ADDR_BITS(20)) bus64 ();

   data_memory_ctrl #(.BITS(32), .ADDR_BITS(20), .DEPTH(100)) u_dut32 (
      .clock(clock), .reset(reset32), .bus(bus32.slave));
   data_memory_ctrl #(.BITS(64), .ADDR_BITS(20), .DEPTH(100)) u_dut64 (
      .clock(clock), .reset(reset64), .bus(bus64.slave));

   typedef struct {
      bit          is64;
      logic        wr;
      logic [1:0]  sz;
      logic        sgn;
      logic [19:0] addr;
      logic [63:0] wd;
      logic [63:0] exp;
      logic        mis;
      logic        rng;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input bit is64, input logic wr, input logic [1:0] sz, input logic sgn,
                      input logic [19:0] addr, input logic [63:0] wd, input logic [63:0] exp,
                      input logic mis, input logic rng);
      vec_t v;
      v.is64 = is64; v.wr = wr; v.sz = sz; v.sgn = sgn; v.addr = addr;
      v.wd = wd; v.exp = exp; v.mis = mis; v.rng = rng;
      vecs.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      if (v.is64) begin
         bus64.req_valid = 1'b1; bus64.req_write = v.wr; bus64.req_size = v.sz;
         bus64.req_signed = v.sgn; bus64.address = v.addr; bus64.wdata = v.wd;
         bus32.req_valid = 1'b0;
      end else begin
         bus32.req_valid = 1'b1; bus32.req_write = v.wr; bus32.req_size = v.sz;
         bus32.req_signed = v.sgn; bus32.address = v.addr; bus32.wdata = v.wd[31:0];
         bus64.req_valid = 1'b0;
      end
   endtask

   task automatic check_rsp(input string tag, input vec_t v);
      if (v.is64) begin
         chk({tag, " rsp_valid"}, 64'(bus64.rsp_valid), 64'd1);
         chk({tag, " rdata"}, bus64.rdata, v.exp);
         chk({tag, " err_misaligned"}, 64'(bus64.err_misaligned), 64'(v.mis));
         chk({tag, " err_range"}, 64'(bus64.err_range), 64'(v.rng));
      end else begin
         chk({tag, " rsp_valid"}, 64'(bus32.rsp_valid), 64'd1);
         chk({tag, " rdata"}, 64'(bus32.rdata), v.exp);
         chk({tag, " err_misaligned"}, 64'(bus32.err_misaligned), 64'(v.mis));
         chk({tag, " err_range"}, 64'(bus32.err_range), 64'(v.rng));
      end
   endtask

   task automatic single(input string tag, input vec_t v);
      drive(v);
      @(posedge clock); #1;
      bus32.req_valid = 1'b0;
      bus64.req_valid = 1'b0;
      check_rsp(tag, v);
   endtask

   task automatic count_busy32(output int cnt, output bit rsp_seen);
      cnt = 0;
      rsp_seen = 0;
      while (bus32.busy && cnt < 1000) begin
         if (bus32.req_ready || bus32.rsp_valid) rsp_seen = 1;
         cnt++;
         @(posedge clock); #1;
      end
   endtask

   int   cnt;
   bit   seen;
   vec_t sv;
   logic [63:0] last32;

   initial begin
      // 32-bit traffic, issued back to back
      add(0, 0, 2, 0, 20'd0,   64'h0,        64'h0,        0, 0);
      add(0, 0, 2, 0, 20'd396, 64'h0,        64'h0,        0, 0);
      add(0, 1, 2, 0, 20'h8,   64'h11223344, 64'h0,        0, 0);
      add(0, 1, 0, 0, 20'hA,   64'h123456F0, 64'h0,        0, 0);
      add(0, 0, 0, 1, 20'hA,   64'h0,        64'hFFFFFFF0, 0, 0);
      add(0, 0, 0, 0, 20'hA,   64'h0,        64'h000000F0, 0, 0);
      add(0, 0, 2, 0, 20'h8,   64'h0,        64'h11F03344, 0, 0);
      add(0, 1, 1, 0, 20'h6,   64'h8001,     64'h0,        0, 0);
      add(0, 0, 1, 1, 20'h6,   64'h0,        64'hFFFF8001, 0, 0);
      add(0, 0, 1, 0, 20'h6,   64'h0,        64'h00008001, 0, 0);
      add(0, 0, 1, 1, 20'h7,   64'h0,        64'h0,        1, 0);
      add(0, 0, 2, 0, 20'h4,   64'h0,        64'h80010000, 0, 0);
      add(0, 1, 2, 0, 20'd400, 64'hDEADBEEF, 64'h0,        0, 1);
      add(0, 0, 2, 0, 20'd396, 64'h0,        64'h0,        0, 0);
      add(0, 1, 2, 0, 20'h3,   64'hA5A5A5A5, 64'h0,        1, 0);
      add(0, 0, 2, 0, 20'h1,   64'h0,        64'h0,        1, 0);
      add(0, 0, 3, 0, 20'h0,   64'h0,        64'h0,        1, 0);
      add(0, 0, 2, 0, 20'd401, 64'h0,        64'h0,        1, 1);
      add(0, 1, 0, 0, 20'hB,   64'hFFFFFF7F, 64'h0,        0, 0);
      add(0, 0, 0, 1, 20'hB,   64'h0,        64'h0000007F, 0, 0);
      add(0, 0, 2, 1, 20'h8,   64'h0,        64'h7FF03344, 0, 0);
      add(0, 1, 1, 0, 20'h2,   64'hFFFFBEEF, 64'h0,        0, 0);
      add(0, 0, 1, 0, 20'h2,   64'h0,        64'h0000BEEF, 0, 0);
      add(0, 0, 1, 1, 20'h2,   64'h0,        64'hFFFFBEEF, 0, 0);
      add(0, 0, 2, 0, 20'h0,   64'h0,        64'hBEEF0000, 0, 0);
      // 64-bit traffic
      add(1, 1, 3, 0, 20'h10,  64'h0123456789ABCDEF, 64'h0,                0, 0);
      add(1, 0, 2, 1, 20'h14,  64'h0,                64'h0000000001234567, 0, 0);
      add(1, 0, 3, 0, 20'h14,  64'h0,                64'h0,                1, 0);
      add(1, 0, 2, 1, 20'h10,  64'h0,                64'hFFFFFFFF89ABCDEF, 0, 0);
      add(1, 0, 2, 0, 20'h10,  64'h0,                64'h0000000089ABCDEF, 0, 0);
      add(1, 0, 3, 0, 20'h10,  64'h0,                64'h0123456789ABCDEF, 0, 0);
      add(1, 0, 1, 1, 20'h12,  64'h0,                64'hFFFFFFFFFFFF89AB, 0, 0);
      add(1, 0, 0, 0, 20'h17,  64'h0,                64'h0000000000000001, 0, 0);
      add(1, 1, 0, 0, 20'h15,  64'hAAAAAAAAAAAAAA80, 64'h0,                0, 0);
      add(1, 0, 3, 0, 20'h10,  64'h0,                64'h0123806789ABCDEF, 0, 0);
      add(1, 0, 0, 1, 20'h15,  64'h0,                64'hFFFFFFFFFFFFFF80, 0, 0);
      add(1, 1, 3, 0, 20'd800, 64'hFFFFFFFFFFFFFFFF, 64'h0,                0, 1);
      add(1, 0, 3, 0, 20'h318, 64'h0,                64'h0,                0, 0);

      bus32.req_valid = 0; bus32.req_write = 0; bus32.req_size = 0; bus32.req_signed = 0;
      bus32.address = '0; bus32.wdata = '0;
      bus64.req_valid = 0; bus64.req_write = 0; bus64.req_size = 0; bus64.req_signed = 0;
      bus64.address = '0; bus64.wdata = '0;
      reset32 = 1; reset64 = 1;
      repeat (3) @(posedge clock);
      #1;
      chk("reset busy", 64'(bus32.busy), 64'd1);
      chk("reset req_ready", 64'(bus32.req_ready), 64'd0);
      chk("reset rsp_valid", 64'(bus32.rsp_valid), 64'd0);
      chk("reset rdata", 64'(bus32.rdata), 64'd0);
      chk("reset busy64", 64'(bus64.busy), 64'd1);
      reset32 = 0; reset64 = 0;

      // Clear sweep after reset
      count_busy32(cnt, seen);
      chk("sweep cycles", 64'(cnt), 64'd100);
      chk("sweep ready", 64'(bus32.req_ready), 64'd1);
      chk("sweep ready64", 64'(bus64.req_ready), 64'd1);

      // Table, back to back
      last32 = '0;
      foreach (vecs[i]) begin
         drive(vecs[i]);
         @(posedge clock); #1;
         check_rsp($sformatf("vec%0d", i), vecs[i]);
         if (!vecs[i].is64) last32 = vecs[i].exp;
      end
      bus32.req_valid = 0; bus64.req_valid = 0;
      @(posedge clock); #1;
      chk("idle rsp_valid64", 64'(bus64.rsp_valid), 64'd0);
      chk("idle rsp_valid32", 64'(bus32.rsp_valid), 64'd0);
      chk("hold rdata32", 64'(bus32.rdata), last32);

      // Reset during a store response
      sv = vecs[2]; sv.addr = 20'h20; sv.wd = 64'h55555555;
      drive(sv);
      @(posedge clock); #1;
      bus32.req_valid = 0;
      chk("store rsp_valid", 64'(bus32.rsp_valid), 64'd1);
      reset32 = 1;
      #1;
      chk("rst rsp_valid now", 64'(bus32.rsp_valid), 64'd0);
      chk("rst ready now", 64'(bus32.req_ready), 64'd0);
      @(posedge clock); #1;
      chk("rst rsp_valid next", 64'(bus32.rsp_valid), 64'd0);
      chk("rst busy next", 64'(bus32.busy), 64'd1);
      reset32 = 0;

      // Reset mid-sweep, with a request held the whole time
      repeat (50) @(posedge clock);
      #1;
      chk("midsweep busy", 64'(bus32.busy), 64'd1);
      reset32 = 1;
      @(posedge clock); #1;
      reset32 = 0;
      sv = vecs[2]; sv.addr = 20'h0; sv.wd = 64'hFFFFFFFF;
      drive(sv);
      count_busy32(cnt, seen);
      bus32.req_valid = 0;
      chk("restart sweep cycles", 64'(cnt), 64'd100);
      chk("sweep ignores req", 64'(seen), 64'd0);
      @(posedge clock); #1;
      chk("no rsp after sweep", 64'(bus32.rsp_valid), 64'd0);

      sv = vecs[0]; sv.addr = 20'h0;  sv.exp = 64'h0; single("clr word0", sv);
      sv = vecs[0]; sv.addr = 20'h8;  sv.exp = 64'h0; single("clr word2", sv);
      sv = vecs[0]; sv.addr = 20'h20; sv.exp = 64'h0; single("clr word8", sv);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Parametrised data memory with sub-word access, the successor to the single-word data memory in the processor datapath. It sits between the execute stage and the memory array and accepts one load or store per cycle over a valid/ready handshake. Stores may be byte, half or word (double when BITS=64). Loads return a right-aligned, zero- or sign-extended result one cycle later. Reset runs a sequential clear sweep instead of clearing the whole array in one cycle.

Parameters:
BITS, 32, word width in bits; legal values are 32 and 64.
ADDR_BITS, 20, width of the byte address.
DEPTH, 100, number of words in the array.

Ports:
clock  in  1  system clock; all state changes on its rising edge.
reset  in  1  synchronous, active-high; restarts the clear sweep.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request this cycle.
req_write  in  1  1 = store, 0 = load.
req_size  in  2  0 = byte, 1 = half, 2 = word(32), 3 = double (64 only).
req_signed  in  1  load result is sign-extended when 1, zero-extended when 0.
address  in  ADDR_BITS  byte address.
wdata  in  BITS  store data, right-aligned.
rsp_valid  out  1  one-cycle pulse; response for the previous accepted request.
rdata  out  BITS  load result; 0 for stores and for errored requests.
err_misaligned  out  1  qualified by rsp_valid.
err_range  out  1  qualified by rsp_valid.
busy  out  1  clear sweep in progress.

Behaviour:
- Reset is synchronous, active-high, on clock.
- While reset=1:
  - State is CLEAR and clear_ptr=0.
  - req_ready=0, rsp_valid=0, rdata=0, err_*=0, busy=1.
- CLEAR state:
  - Writes zero to word[clear_ptr] each cycle and increments clear_ptr.
  - When clear_ptr=DEPTH-1 is written, the next state is READY.
  - The sweep takes DEPTH cycles after reset deasserts.
  - busy=1 and req_ready=0 throughout.
  - Reset asserted mid-sweep restarts the sweep from 0.
  - req_valid is ignored in CLEAR.
- READY state:
  - busy=0 and req_ready=1.
  - A request is accepted when req_valid=1 in READY.
  - There are no other state transitions except reset.
- Address decode:
  - LB = log2(BITS/8).
  - word index = address >> LB.
  - Byte offset = address[LB-1:0].
- Error checks (errors take priority over the access):
  - err_range: word index >= DEPTH.
  - err_misaligned:
    - half with offset[0]=1;
    - word with offset[1:0]!=0;
    - double with offset!=0;
    - size 3 when BITS=32 (treated as misaligned).
  - Both flags may be set together.
  - An errored request does not modify memory and returns rdata=0.
- Store:
  - Only the addressed lanes are written: 1, 2, 4 or 8 bytes starting at the offset, taken from the low bytes of wdata.
  - Other bytes of the word are unchanged.
  - The write takes effect on the accepting edge.
- Load:
  - Reads the addressed lanes, shifts them to bit 0, and extends to BITS.
  - Extension is by the lane MSB when req_signed=1, by zero otherwise.
  - A word load with BITS=32 ignores req_signed.
- Response timing:
  - Registered: rsp_valid=1 in the cycle after acceptance, for loads and stores alike.
  - There is no response backpressure.
  - rdata and err_* hold their values until the next response.
  - Back-to-back requests produce back-to-back responses.
- Read-after-write: a load accepted in the cycle after a store to the same word sees the stored data.
- Unaccepted cycles: rsp_valid=0 the next cycle.

Test Plan:
- Reset sweep:
  - Stimulus: DEPTH=100; hold reset 3 cycles, then release.
  - Required: busy=1 and req_ready=0 for exactly 100 cycles; then req_ready=1; loads of words 0 and 99 return 0.
- Byte store and signed load:
  - Stimulus: SW 0x11223344 at address 0x8; SB 0xF0 at address 0xA; LB signed at 0xA; LBU at 0xA; LW at 0x8.
  - Required: 0xFFFFFFF0; 0x000000F0; 0x11F03344.
- Halfword access:
  - Stimulus: SH 0x8001 at address 0x6; LH signed at 0x6; LHU at 0x6.
  - Required: 0xFFFF8001; 0x00008001.
  - Stimulus: LH at 0x7.
  - Required: err_misaligned=1, rdata=0, memory unchanged.
- Range error:
  - Stimulus: SW at address 400 (word 100, DEPTH=100).
  - Required: err_range=1; a subsequent LW of word 99 is unchanged.
- Reset mid-sweep and mid-traffic:
  - Stimulus: reset 1 cycle at sweep cycle 50.
  - Required: sweep restarts and busy lasts 100 more cycles.
  - Stimulus: reset during a store response.
  - Required: rsp_valid=0 the next cycle.
- BITS=64:
  - Stimulus: SD 0x0123456789ABCDEF at address 0x10; LW signed at 0x14; a double access at 0x14.
  - Required: 0x0000000001234567; err_misaligned=1.
